// File: rtl/goertzel_result_reader_if.sv
// Result stream from the Goertzel reader: one bin per beat, valid/ready handshake.
interface goertzel_result_reader_if #(
  parameter int IW = 4
);
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic [IW-1:0] m_idx;
  logic          m_last;

  modport master (output m_valid, output m_data, output m_idx, output m_last, input  m_ready);
  modport slave  (input  m_valid, input  m_data, input  m_idx, input  m_last, output m_ready);
endinterface

// File: rtl/goertzel_result_reader.sv
// Snapshots all Goertzel bin magnitudes once every bin reports valid, finds the peak,
// compares it with a captured threshold and streams the bins out lowest index first.
module goertzel_result_reader #(
  parameter int NF = 11,
  parameter int IW = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NF-1:0]        valid_i,
  input  logic [NF*32-1:0]     data_i,
  input  logic [31:0]          thr_i,
  goertzel_result_reader_if.master m,
  output logic                 peak_valid,
  output logic [IW-1:0]        peak_idx,
  output logic [31:0]          peak_val,
  output logic                 peak_hit,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IW-1:0] LAST = IW'(NF - 1);

  logic [1:0]    state_q, state_d;
  logic          trig_q;
  logic [31:0]   buf_q [NF];
  logic [31:0]   thr_q, thr_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          peak_valid_q, peak_valid_d;
  logic [IW-1:0] peak_idx_q, peak_idx_d;
  logic [31:0]   peak_val_q, peak_val_d;
  logic          peak_hit_q, peak_hit_d;
  logic          m_valid_q, m_valid_d;
  logic [31:0]   m_data_q, m_data_d;
  logic [IW-1:0] m_idx_q, m_idx_d;
  logic          m_last_q, m_last_d;
  logic          done_q, done_d;

  logic all_v, trigger;

  // Edge-detect on "all bins valid" so a held valid_i yields exactly one frame.
  assign all_v   = &valid_i;
  assign trigger = all_v && !trig_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    thr_d        = thr_q;
    cnt_d        = cnt_q;
    peak_valid_d = peak_valid_q;
    peak_idx_d   = peak_idx_q;
    peak_val_d   = peak_val_q;
    peak_hit_d   = peak_hit_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_idx_d      = m_idx_q;
    m_last_d     = m_last_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          thr_d        = thr_i;
          peak_valid_d = 1'b0;
          peak_val_d   = '0;
          peak_idx_d   = '0;
          cnt_d        = '0;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if (buf_q[cnt_q] > peak_val_q) begin
          peak_val_d = buf_q[cnt_q];
          peak_idx_d = cnt_q;
        end
        if (cnt_q == LAST) begin
          state_d      = S_SEND;
          peak_valid_d = 1'b1;
          peak_hit_d   = (peak_val_d >= thr_q);
          m_valid_d    = 1'b1;
          m_idx_d      = '0;
          m_data_d     = buf_q[0];
          m_last_d     = (NF == 1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        if (m_valid_q && m.m_ready) begin
          if (m_idx_q == LAST) begin
            m_valid_d = 1'b0;
            state_d   = S_DONE;
            done_d    = 1'b1;
          end else begin
            m_idx_d  = m_idx_q + 1'b1;
            m_data_d = buf_q[m_idx_d];
            m_last_d = (m_idx_d == LAST);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      trig_q       <= 1'b0;
      thr_q        <= '0;
      cnt_q        <= '0;
      peak_valid_q <= 1'b0;
      peak_idx_q   <= '0;
      peak_val_q   <= '0;
      peak_hit_q   <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_idx_q      <= '0;
      m_last_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_q       <= all_v;
      thr_q        <= thr_d;
      cnt_q        <= cnt_d;
      peak_valid_q <= peak_valid_d;
      peak_idx_q   <= peak_idx_d;
      peak_val_q   <= peak_val_d;
      peak_hit_q   <= peak_hit_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_idx_q      <= m_idx_d;
      m_last_q     <= m_last_d;
      done_q       <= done_d;
    end
  end

  // NOTE: the snapshot is reset so the debug readout never shows stale frames after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NF; i++) buf_q[i] <= '0;
    end else if (state_q == S_IDLE && trigger) begin
      for (int i = 0; i < NF; i++) buf_q[i] <= data_i[32*i +: 32];
    end
  end

  assign m.m_valid  = m_valid_q;
  assign m.m_data   = m_data_q;
  assign m.m_idx    = m_idx_q;
  assign m.m_last   = m_last_q;
  assign peak_valid = peak_valid_q;
  assign peak_idx   = peak_idx_q;
  assign peak_val   = peak_val_q;
  assign peak_hit   = peak_hit_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule
